// File: rtl/contador_limite_parametrizado.sv
// Parametrised up/down counter with a programmable terminal value and a choice
// between wrapping and saturating at that terminal. It also produces an
// end-of-count pulse.
module contador_limite_parametrizado #(
  parameter int WIDTH      = 4,
  parameter int LIMITE     = 7,
  parameter int RECICLAVEL = 0
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Enable,
  input  logic             Direcao,
  input  logic             Carga,
  input  logic [WIDTH-1:0] Valor,
  output logic [WIDTH-1:0] Contagem,
  output logic             saida,
  output logic             Pulso_fim
);

  localparam logic [WIDTH-1:0] LIM  = WIDTH'(LIMITE);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] contagem_q, contagem_d;
  logic             pulso_q, pulso_d;
  logic [WIDTH-1:0] terminal, inicio, carga_val, passo;

  // Terminal and restart points swap roles with the counting direction
  always_comb begin
    terminal  = Direcao ? ZERO : LIM;
    inicio    = Direcao ? LIM  : ZERO;
    carga_val = (Valor > LIM) ? LIM : Valor;
    passo     = Direcao ? (contagem_q - ONE) : (contagem_q + ONE);
  end

  always_comb begin
    contagem_d = contagem_q;
    pulso_d    = 1'b0;
    if (Clear) begin
      contagem_d = ZERO;
    end else if (Carga) begin
      contagem_d = carga_val;
    end else if (Enable) begin
      if (contagem_q == terminal) begin
        if (RECICLAVEL != 0) begin
          contagem_d = inicio;
        end
      end else begin
        contagem_d = passo;
        pulso_d    = (passo == terminal);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      contagem_q <= ZERO;
      pulso_q    <= 1'b0;
    end else begin
      contagem_q <= contagem_d;
      pulso_q    <= pulso_d;
    end
  end

  assign Contagem  = contagem_q;
  assign Pulso_fim = pulso_q;
  assign saida     = (contagem_q == terminal);

endmodule
